mem_bus_unit: RTL and testbench
===============================

Name: mem_bus_unit

Overview:
- Memory-access stage sitting directly downstream of the multicycle controller/datapath address mux.
- Turns single-state fetch/load/store requests into a variable-latency req/ack bus transaction with byte enables.
- Stalls the controller FSM until the transaction completes.
- Holds the instruction register and the load-data register, with lane extraction and sign/zero extension.

Parameters:
TIMEOUT_CYCLES, 255, bus cycles to wait for bus_ack before flagging an error; 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req_valid  input  1  controller is in a memory state; held until done
req_fetch  input  1  request is an instruction fetch; the result loads instr
req_write  input  1  store (ignored when req_fetch=1)
req_addr  input  32  byte address (PC or ALU result)
req_wdata  input  32  store data (rs2)
req_funct3  input  3  access size/sign: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
stall  output  1  controller must hold its state
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse with done: misaligned, illegal size, or timeout
instr  output  32  instruction register
rdata  output  32  extended load data register
bus_req  output  1  bus request
bus_we  output  1  bus write
bus_addr  output  32  word-aligned address, {req_addr[31:2],2'b00}
bus_be  output  4  byte enables
bus_wdata  output  32  lane-replicated store data
bus_rdata  input  32  bus read data
bus_ack  input  1  bus completion, sampled only in REQ

Behaviour:
- Reset (async, immediate) values:
  - state=IDLE.
  - stall, done, err, bus_req, bus_we = 0.
  - bus_addr, bus_be, bus_wdata, instr, rdata, timeout counter = 0.
- Reset mid-transaction: bus_req drops immediately; the in-flight result is discarded.
- States: IDLE, REQ, DONE, ERR.
- IDLE:
  - stall = req_valid (combinational).
  - On req_valid, latch addr/size/write/fetch/wdata and check legality:
    - fetch: addr[1:0]=00.
    - 010: addr[1:0]=00.
    - 001/101: addr[0]=0.
    - 000/100: any address.
    - Any other funct3 on a non-fetch request is illegal.
  - Legal -> REQ. Illegal -> ERR; no bus transaction is issued.
- REQ:
  - bus_req=1, stall=1.
  - bus_addr, bus_we, bus_be and bus_wdata come from registers and are stable throughout.
  - Counter increments each cycle.
  - On bus_ack:
    - Fetch: instr <= bus_rdata.
    - Load: rdata <= extended lane data.
    - Store: registers unchanged.
    - Next state DONE.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES with no ack -> ERR; bus_req drops.
  - An ack on the same cycle as the timeout wins and goes to DONE.
- DONE: done=1, stall=0; next state IDLE. req_valid is ignored here; a new request is accepted in IDLE the following cycle.
- ERR: done=1, err=1, stall=0; next state IDLE. instr and rdata are unchanged.
- Latency: with ack in the first REQ cycle, done asserts 2 cycles after req_valid is first sampled.
- Byte enables (reads and writes alike):
  - fetch/word: 1111.
  - half: 0011 if addr[1]=0, else 1100.
  - byte: 0001<<addr[1:0].
- bus_wdata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- Load extraction:
  - Select the byte or halfword by addr[1:0].
  - 000/001 sign-extend; 100/101 zero-extend; 010 passes through.
- bus_ack outside REQ has no effect.

Test Plan:
- Fetch addr 0x00000010, ack after 3 REQ cycles, bus_rdata=0x00500113 -> bus_addr=0x10, be=1111, stall high for 4 cycles, instr=0x00500113, one done pulse, err=0.
- lb addr 0x1003, bus_rdata=0x80FF_1234 -> be=1000, rdata=0xFFFFFF80. lbu, same stimulus -> rdata=0x00000080.
- sh addr 0x2002, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, rdata unchanged.
- lw addr 0x1001 -> no bus_req ever asserted, done+err pulse in the 2nd cycle.
- Timeout: TIMEOUT_CYCLES=4, load with no ack -> bus_req high exactly 4 cycles, then done+err. Ack on the 4th cycle -> normal DONE, err=0.
- Assert reset during REQ -> bus_req=0 immediately, stall=0, instr/rdata=0. Next request after reset completes normally.

Source files
------------

// File: rtl/mem_bus_unit.sv
// mem_bus_unit: memory-access stage between the multicycle controller and a
// variable-latency req/ack bus. It converts a single-state fetch/load/store
// request into one bus transaction, stalls the controller until the bus
// completes, and owns the instruction register and the extended load-data register.
module mem_bus_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_fetch,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] instr,
  output logic [31:0] rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  // A value of zero disables the bus timeout entirely.
  localparam logic [31:0] TMO = 32'(TIMEOUT_CYCLES);

  state_t      state_reg;
  state_t      state_next;

  // Request captured in IDLE and held for the whole transaction.
  logic        fetch_reg;
  logic        we_reg;
  logic [2:0]  funct3_reg;
  logic [1:0]  off_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] cnt_reg;
  logic [31:0] instr_reg;
  logic [31:0] rdata_reg;

  // Decode of the incoming request.
  logic [2:0]  size_f3;
  logic        legal;
  logic [3:0]  byte_hit;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Transaction progress and load-lane extraction.
  logic        timeout_hit;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;

  // A fetch always moves a full word regardless of funct3.
  assign size_f3 = req_fetch ? 3'b010 : req_funct3;

  // One-hot lane select for byte accesses.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_hit[gi] = (req_addr[1:0] == 2'(gi));
    end
  endgenerate

  // Alignment and size legality of the incoming request.
  always_comb begin
    legal = 1'b0;
    if (req_fetch) begin
      legal = (req_addr[1:0] == 2'b00);
    end else begin
      case (req_funct3)
        3'b000, 3'b100: legal = 1'b1;
        3'b001, 3'b101: legal = ~req_addr[0];
        3'b010:         legal = (req_addr[1:0] == 2'b00);
        default:        legal = 1'b0;
      endcase
    end
  end

  // Byte enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_next    = 4'b1111;
    wdata_next = req_wdata;
    case (size_f3[1:0])
      2'b00: begin
        be_next    = byte_hit;
        wdata_next = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_next    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{req_wdata[15:0]}};
      end
      default: begin
        be_next    = 4'b1111;
        wdata_next = req_wdata;
      end
    endcase
  end

  // Select the addressed byte/halfword of the bus word and extend it.
  always_comb begin
    ld_byte = 8'h00;
    case (off_reg)
      2'b00:   ld_byte = bus_rdata[7:0];
      2'b01:   ld_byte = bus_rdata[15:8];
      2'b10:   ld_byte = bus_rdata[23:16];
      default: ld_byte = bus_rdata[31:24];
    endcase
    ld_half = off_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (funct3_reg)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_ext = {24'h000000, ld_byte};
      3'b101:  ld_ext = {16'h0000, ld_half};
      default: ld_ext = bus_rdata;
    endcase
  end

  // The counter holds the number of REQ cycles already completed, so the
  // last permitted cycle is the one where it equals TMO-1.
  assign timeout_hit = (TMO != 32'd0) && (cnt_reg == (TMO - 32'd1));

  // State register; reset abandons any in-flight transaction at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    stall      = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    bus_req    = 1'b0;
    bus_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        stall = req_valid;
        if (req_valid) begin
          state_next = legal ? REQ : ERR;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        bus_we  = we_reg;
        stall   = 1'b1;
        // An ack in the timeout cycle still completes normally.
        if (bus_ack) begin
          state_next = DONE;
        end else if (timeout_hit) begin
          state_next = ERR;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        err        = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture, timeout counting and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_reg  <= 1'b0;
      we_reg     <= 1'b0;
      funct3_reg <= 3'b000;
      off_reg    <= 2'b00;
      addr_reg   <= 32'h0;
      wdata_reg  <= 32'h0;
      be_reg     <= 4'h0;
      cnt_reg    <= 32'h0;
      instr_reg  <= 32'h0;
      rdata_reg  <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          cnt_reg <= 32'h0;
          if (req_valid) begin
            fetch_reg  <= req_fetch;
            we_reg     <= req_write & ~req_fetch;
            funct3_reg <= size_f3;
            off_reg    <= req_addr[1:0];
            addr_reg   <= {req_addr[31:2], 2'b00};
            wdata_reg  <= wdata_next;
            be_reg     <= be_next;
          end
        end
        REQ: begin
          cnt_reg <= cnt_reg + 32'd1;
          if (bus_ack) begin
            if (fetch_reg) begin
              instr_reg <= bus_rdata;
            end else if (!we_reg) begin
              rdata_reg <= ld_ext;
            end
          end
        end
        default: begin
          cnt_reg <= 32'h0;
        end
      endcase
    end
  end

  assign instr     = instr_reg;
  assign rdata     = rdata_reg;
  assign bus_addr  = addr_reg;
  assign bus_be    = be_reg;
  assign bus_wdata = wdata_reg;

endmodule

// File: tb/tb_mem_bus_unit.sv
// Testbench for mem_bus_unit: directed scenarios followed by randomized
// transactions, compared against a transaction-level reference model.
module tb_mem_bus_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_fetch;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] instr;
  logic [31:0] rdata;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int pass_count = 0;
  int fail_count = 0;
  int total_count = 0;

  // Reference-model architectural state.
  logic [31:0] exp_instr = 32'h0;
  logic [31:0] exp_rdata = 32'h0;

  mem_bus_unit #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_fetch  (req_fetch),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .stall      (stall),
    .done       (done),
    .err        (err),
    .instr      (instr),
    .rdata      (rdata),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_rdata  (bus_rdata),
    .bus_ack    (bus_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_count = total_count + 1;
    assert (obs === exp) begin
      pass_count = pass_count + 1;
    end else begin
      fail_count = fail_count + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction. ack_at = REQ cycle (1-based) on which the bus
  // acks; 0 or beyond the timeout means the bus never answers.
  task automatic run_txn(input bit fetch, input bit write, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [2:0] f3,
                         input int ack_at, input logic [31:0] rd, input string name);
    bit          legal;
    bit          acked;
    bit          ewe;
    int          nbytes;
    int          m;
    int          exp_req;
    int          exp_done_cyc;
    int          req_cycles;
    int          stall_cycles;
    int          done_cyc;
    logic [3:0]  ebe;
    logic [31:0] ewd;
    logic [31:0] eaddr;
    logic [63:0] lane;

    // Reference model: legality, size, lanes, outcome.
    nbytes = 4;
    if (fetch) begin
      legal = (addr[1:0] == 2'b00);
    end else begin
      case (f3)
        3'b000, 3'b100: begin legal = 1'b1; nbytes = 1; end
        3'b001, 3'b101: begin legal = (addr[0] == 1'b0); nbytes = 2; end
        3'b010:         begin legal = (addr[1:0] == 2'b00); end
        default:        begin legal = 1'b0; end
      endcase
    end
    m = ((1 << nbytes) - 1) << int'(addr[1:0]);
    ebe = m[3:0];
    for (int i = 0; i < 4; i++) begin
      ewd[8*i +: 8] = wdata[8*(i % nbytes) +: 8];
    end
    eaddr = addr & 32'hFFFF_FFFC;
    ewe = write && !fetch;
    acked = legal && (ack_at >= 1) && (ack_at <= TMO);
    exp_req = !legal ? 0 : (acked ? ack_at : TMO);
    exp_done_cyc = exp_req + 2;
    if (acked) begin
      if (fetch) begin
        exp_instr = rd;
      end else if (!ewe) begin
        lane = {32'h0, rd} >> (8 * int'(addr[1:0]));
        lane = lane & ((64'd1 << (8 * nbytes)) - 64'd1);
        if (!f3[2] && nbytes < 4 && lane[8*nbytes-1]) begin
          lane = lane - (64'd1 << (8 * nbytes));
        end
        exp_rdata = lane[31:0];
      end
    end

    req_cycles = 0;
    stall_cycles = 0;
    done_cyc = 0;
    @(negedge clk);
    req_valid  = 1'b1;
    req_fetch  = fetch;
    req_write  = write;
    req_addr   = addr;
    req_wdata  = wdata;
    req_funct3 = f3;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (done) begin
        done_cyc = cyc;
        check({name, ":err"}, 32'(err), 32'(!acked));
        check({name, ":instr"}, instr, exp_instr);
        check({name, ":rdata"}, rdata, exp_rdata);
        req_valid = 1'b0;
      end
      if (bus_req) begin
        req_cycles++;
        check({name, ":bus_addr"}, bus_addr, eaddr);
        check({name, ":bus_be"}, 32'(bus_be), 32'(ebe));
        check({name, ":bus_we"}, 32'(bus_we), 32'(ewe));
        if (ewe) check({name, ":bus_wdata"}, bus_wdata, ewd);
        bus_ack = (req_cycles == ack_at);
        bus_rdata = bus_ack ? rd : $urandom;
      end else begin
        // Acks outside REQ must be ignored.
        bus_ack = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
      end
      #1;
      if (stall) stall_cycles++;
      if (done_cyc != 0) break;
    end
    check({name, ":done_cycle"}, 32'(done_cyc), 32'(exp_done_cyc));
    check({name, ":req_cycles"}, 32'(req_cycles), 32'(exp_req));
    check({name, ":stall_cycles"}, 32'(stall_cycles), 32'(1 + exp_req));
    @(negedge clk);
    check({name, ":done_pulse"}, 32'(done), 32'h0);
    bus_ack = 1'b0;
    $display("txn %s fetch=%0d we=%0d addr=%h f3=%b ack_at=%0d -> done@%0d req=%0d err=%0d instr=%h rdata=%h",
             name, fetch, write, addr, f3, ack_at, done_cyc, req_cycles, !acked, instr, rdata);
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 1'b0;
    req_fetch = 1'b0;
    req_write = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;
    req_funct3 = 3'b000;
    bus_rdata = 32'h0;
    bus_ack = 1'b0;
    #3;
    check("rst:stall", 32'(stall), 32'h0);
    check("rst:done", 32'(done), 32'h0);
    check("rst:err", 32'(err), 32'h0);
    check("rst:bus_req", 32'(bus_req), 32'h0);
    check("rst:bus_we", 32'(bus_we), 32'h0);
    check("rst:bus_addr", bus_addr, 32'h0);
    check("rst:bus_be", 32'(bus_be), 32'h0);
    check("rst:bus_wdata", bus_wdata, 32'h0);
    check("rst:instr", instr, 32'h0);
    check("rst:rdata", rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Directed scenarios.
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, 3'b010, 3, 32'h0050_0113, "fetch");
    check("fetch:instr_const", instr, 32'h0050_0113);
    run_txn(1'b0, 1'b0, 32'h0000_1003, 32'h0, 3'b000, 1, 32'h80FF_1234, "lb");
    check("lb:rdata_const", rdata, 32'hFFFF_FF80);
    run_txn(1'b0, 1'b0, 32'h0000_1003, 32'h0, 3'b100, 1, 32'h80FF_1234, "lbu");
    check("lbu:rdata_const", rdata, 32'h0000_0080);
    run_txn(1'b0, 1'b1, 32'h0000_2002, 32'h0000_ABCD, 3'b001, 2, 32'h1111_2222, "sh");
    check("sh:rdata_kept", rdata, 32'h0000_0080);
    run_txn(1'b0, 1'b0, 32'h0000_1001, 32'h0, 3'b010, 1, 32'hDEAD_BEEF, "lw_misaligned");
    run_txn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 3'b010, 0, 32'h1234_5678, "lw_timeout");
    run_txn(1'b0, 1'b0, 32'h0000_1000, 32'h0, 3'b010, TMO, 32'h1234_5678, "lw_ack_last");
    run_txn(1'b0, 1'b0, 32'h0000_1006, 32'h0, 3'b001, 2, 32'h8001_7FFF, "lh_hi");
    run_txn(1'b0, 1'b0, 32'h0000_1004, 32'h0, 3'b101, 1, 32'h8001_F00F, "lhu_lo");
    run_txn(1'b0, 1'b0, 32'h0000_1004, 32'h0, 3'b011, 1, 32'h0, "illegal_f3");

    // Reset while a transaction is waiting for ack.
    @(negedge clk);
    req_valid = 1'b1; req_fetch = 1'b0; req_write = 1'b0;
    req_addr = 32'h0000_3000; req_funct3 = 3'b010; bus_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst:bus_req_before", 32'(bus_req), 32'h1);
    #2;
    reset = 1'b1;
    req_valid = 1'b0;
    #1;
    check("midrst:bus_req", 32'(bus_req), 32'h0);
    check("midrst:stall", 32'(stall), 32'h0);
    check("midrst:instr", instr, 32'h0);
    check("midrst:rdata", rdata, 32'h0);
    check("midrst:done", 32'(done), 32'h0);
    exp_instr = 32'h0;
    exp_rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    run_txn(1'b0, 1'b0, 32'h0000_3002, 32'h0, 3'b001, 2, 32'h9ABC_0000, "after_reset");

    // Randomized transactions.
    for (int n = 0; n < 40; n++) begin
      run_txn(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), $urandom,
              $urandom, 3'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
              $urandom, $sformatf("rnd%0d", n));
    end

    $display("%0d/%0d checks passed", pass_count, total_count);
    $finish;
  end

endmodule
